tone_arbiter: RTL

- Shares the single piezo tone_generator between two requesters: the music_streamer (background, continuous) and a UI beeper (foreground, one-shot beeps of fixed length).
- Sits between music_streamer.tone and tone_generator.tone_switch_period / output_enable.
- A beep pre-empts the streamer, is followed by a silent gap, then control returns to the streamer.

---
 rtl/tone_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/tone_arbiter.sv
// tone_arbiter: shares one tone_generator between the background music
// streamer and a foreground UI beeper. A beep pre-empts the streamer, is
// followed by a silent gap, and then control returns to the streamer.
//
// Build option TONE_ARB_QUEUE_EN:
//   defined   - one-deep pending-beep buffer; a start that arrives during
//               BEEP/GAP is held and played after the current gap.
//   undefined - only STREAM accepts beeps; any other start is dropped.
//
// Every output is registered. tone/output_enable follow the state the
// arbiter is in during the sampling cycle, so a new beep shows up one edge
// after its start is taken. beep_active follows the next state instead.
// An abort acts on the outputs in the same cycle it is sampled.

module tone_arbiter #(
  parameter int TONE_W      = 24,
  parameter int CNT_W       = 24,
  parameter int BEEP_CYCLES = 3300000,
  parameter int GAP_CYCLES  = 330000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TONE_W-1:0] stream_tone,
  input  logic              stream_enable,
  input  logic              beep_start,
  input  logic [TONE_W-1:0] beep_tone,
  input  logic              beep_abort,
  output logic [TONE_W-1:0] tone,
  output logic              output_enable,
  output logic              beep_active,
  output logic              beep_done,
  output logic              beep_dropped
);

  localparam logic [1:0] ST_STREAM = 2'd0;
  localparam logic [1:0] ST_BEEP   = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TONE_W-1:0] lat_tone_q, lat_tone_d;
  logic [TONE_W-1:0] tone_q, tone_d;
  logic              oe_q, oe_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic              dropped_q, dropped_d;
  logic [1:0]        out_state;

`ifdef TONE_ARB_QUEUE_EN
  logic              pend_valid_q, pend_valid_d;
  logic [TONE_W-1:0] pend_tone_q, pend_tone_d;
`endif

  // Next-state, duration counter, beep tone latch and request bookkeeping.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_tone_d = lat_tone_q;
    done_d     = 1'b0;
    dropped_d  = 1'b0;
`ifdef TONE_ARB_QUEUE_EN
    pend_valid_d = pend_valid_q;
    pend_tone_d  = pend_tone_q;
`endif

    case (state_q)
      ST_STREAM: begin
        if (beep_start) begin
          state_d    = ST_BEEP;
          cnt_d      = '0;
          lat_tone_d = beep_tone;
        end
      end
      ST_BEEP: begin
        if (cnt_q == BEEP_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_STREAM;
`ifdef TONE_ARB_QUEUE_EN
          if (pend_valid_q) begin
            // Queued beep takes priority over anything arriving right now.
            state_d      = ST_BEEP;
            lat_tone_d   = pend_tone_q;
            pend_valid_d = 1'b0;
          end else if (beep_start) begin
            // Empty buffer on the final gap cycle: start the beep directly.
            state_d    = ST_BEEP;
            lat_tone_d = beep_tone;
          end
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STREAM;
        cnt_d   = '0;
      end
    endcase

    // Requests arriving while a beep or gap is in progress.
    if (beep_start && (state_q != ST_STREAM)) begin
`ifdef TONE_ARB_QUEUE_EN
      if (pend_valid_q) begin
        dropped_d = 1'b1;
      end else if (!((state_q == ST_GAP) && (cnt_q == GAP_LAST))) begin
        pend_valid_d = 1'b1;
        pend_tone_d  = beep_tone;
      end
`else
      dropped_d = 1'b1;
`endif
    end

    // Abort beats everything, including a simultaneous start or completion.
    if (beep_abort) begin
      state_d   = ST_STREAM;
      cnt_d     = '0;
      done_d    = 1'b0;
      dropped_d = 1'b0;
`ifdef TONE_ARB_QUEUE_EN
      pend_valid_d = 1'b0;
`endif
    end
  end

  // Output selection: an abort hands the piezo back to the streamer at once.
  always_comb begin
    out_state = beep_abort ? ST_STREAM : state_q;
    tone_d    = '0;
    oe_d      = 1'b0;
    case (out_state)
      ST_STREAM: begin
        tone_d = stream_tone;
        oe_d   = stream_enable;
      end
      ST_BEEP: begin
        tone_d = lat_tone_q;
        oe_d   = (lat_tone_q != '0);
      end
      default: begin
        tone_d = '0;
        oe_d   = 1'b0;
      end
    endcase
    active_d = (state_d != ST_STREAM);
  end

  // State, counter and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_STREAM;
      cnt_q      <= '0;
      lat_tone_q <= '0;
      tone_q     <= '0;
      oe_q       <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_tone_q <= lat_tone_d;
      tone_q     <= tone_d;
      oe_q       <= oe_d;
      active_q   <= active_d;
      done_q     <= done_d;
      dropped_q  <= dropped_d;
    end
  end

`ifdef TONE_ARB_QUEUE_EN
  // Pending-beep buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid_q <= 1'b0;
      pend_tone_q  <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_tone_q  <= pend_tone_d;
    end
  end
`endif

  assign tone          = tone_q;
  assign output_enable = oe_q;
  assign beep_active   = active_q;
  assign beep_done     = done_q;
  assign beep_dropped  = dropped_q;

endmodule
